regfile_selfcheck: RTL and testbench

REGFILE_SELFCHECK -- requirements
Module: regfile_selfcheck

---
 rtl/regfile_selfcheck_pkg.sv | 22 ++
 rtl/selfcheck_cmp.sv | 52 +++++
 rtl/regfile_selfcheck.sv | 145 ++++++++++++++
 tb/tb_regfile_selfcheck.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_selfcheck_pkg.sv
// Shared state encoding and width helpers for the register-file self-check sequencer.
package regfile_selfcheck_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  // Bits needed to hold a count of 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n entries, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/selfcheck_cmp.sv
// Registered dual-channel compare: counts matching reads and latches the lowest failing entry.
module selfcheck_cmp
  import regfile_selfcheck_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_CHECKS = 12
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            cmp_en,
  input  logic                            b_valid,
  input  logic [DATA_W-1:0]               data_a,
  input  logic [DATA_W-1:0]               data_b,
  input  logic [DATA_W-1:0]               exp_a,
  input  logic [DATA_W-1:0]               exp_b,
  input  logic [idx_w(NUM_CHECKS)-1:0]    idx_a,
  input  logic [idx_w(NUM_CHECKS)-1:0]    idx_b,
  output logic [cnt_w(NUM_CHECKS)-1:0]    num_correct,
  output logic                            fail_valid,
  output logic [idx_w(NUM_CHECKS)-1:0]    first_fail_idx
);

  localparam int CW = cnt_w(NUM_CHECKS);

  logic match_a, match_b, miss_a, miss_b;

  assign match_a = (data_a == exp_a);
  assign match_b = b_valid && (data_b == exp_b);
  assign miss_a  = !match_a;
  assign miss_b  = b_valid && !match_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_correct    <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (clear) begin
      num_correct    <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (cmp_en) begin
      num_correct <= num_correct + CW'(match_a) + CW'(match_b);
      // A is the lower entry of the pair, so it wins when both miss.
      if (!fail_valid && (miss_a || miss_b)) begin
        fail_valid     <= 1'b1;
        first_fail_idx <= miss_a ? idx_a : idx_b;
      end
    end
  end

endmodule

// File: rtl/regfile_selfcheck.sv
// Lets the processor run for a fixed time, then sweeps the register-file test port two
// entries per pair and reports how many read back as expected.
module regfile_selfcheck
  import regfile_selfcheck_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_CHECKS = 12,
  parameter int RUN_CYCLES = 100,
  parameter int READ_LAT   = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_CHECKS*ADDR_W-1:0]    exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0]    exp_value,
  input  logic [DATA_W-1:0]               rd_data_a,
  input  logic [DATA_W-1:0]               rd_data_b,
  output logic                            test,
  output logic                            t_ctrl_writeEnable,
  output logic [ADDR_W-1:0]               rd_addr_a,
  output logic [ADDR_W-1:0]               rd_addr_b,
  output logic                            busy,
  output logic                            done,
  output logic                            pass_all,
  output logic [cnt_w(NUM_CHECKS)-1:0]    num_correct,
  output logic                            fail_valid,
  output logic [idx_w(NUM_CHECKS)-1:0]    first_fail_idx
);

  localparam int CW     = cnt_w(NUM_CHECKS);
  localparam int IW     = idx_w(NUM_CHECKS);
  localparam int NPAIRS = (NUM_CHECKS + 1) / 2;
  localparam int PW     = idx_w(NPAIRS);
  localparam int RW     = cnt_w(RUN_CYCLES);

  state_t          state, state_n;
  logic [RW-1:0]   run_cnt;
  logic [PW-1:0]   pair;
  logic [1:0]      wait_cnt;
  logic            cmp_en, clear, pair_last, b_valid;
  logic [DATA_W-1:0] exp_a, exp_b;
  int              a_idx, b_idx;

  assign pair_last          = (pair == PW'(NPAIRS - 1));
  assign test               = (state == S_ISSUE) || (state == S_WAIT);
  assign busy               = (state == S_RUN) || test;
  assign t_ctrl_writeEnable = 1'b0;

  always_comb begin
    state_n = state;
    cmp_en  = 1'b0;
    clear   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (run_cnt == RW'(1)) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (READ_LAT == 0) begin
          cmp_en = 1'b1;
          if (pair_last) state_n = S_FINISH;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 2'(READ_LAT - 1)) begin
          cmp_en  = 1'b1;
          state_n = pair_last ? S_FINISH : S_ISSUE;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      run_cnt  <= '0;
      pair     <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
      pass_all <= 1'b0;
    end else begin
      state <= state_n;
      if (clear) begin
        run_cnt  <= RW'(RUN_CYCLES);
        pair     <= '0;
        done     <= 1'b0;
        pass_all <= 1'b0;
      end
      if (state == S_RUN) run_cnt <= run_cnt - RW'(1);
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (cmp_en && !pair_last) pair <= pair + PW'(1);
      if (state == S_FINISH) begin
        done     <= 1'b1;
        pass_all <= (num_correct == CW'(NUM_CHECKS));
      end
    end
  end

  // Odd entry counts leave channel B of the last pair without an entry; it reads address 0.
  always_comb begin
    a_idx     = 2 * int'(pair);
    b_valid   = (a_idx + 1) < NUM_CHECKS;
    b_idx     = b_valid ? (a_idx + 1) : 0;
    exp_a     = exp_value[a_idx*DATA_W +: DATA_W];
    exp_b     = exp_value[b_idx*DATA_W +: DATA_W];
    rd_addr_a = '0;
    rd_addr_b = '0;
    if (test) begin
      rd_addr_a = exp_addr[a_idx*ADDR_W +: ADDR_W];
      if (b_valid) rd_addr_b = exp_addr[b_idx*ADDR_W +: ADDR_W];
    end
  end

  selfcheck_cmp #(
    .DATA_W     (DATA_W),
    .NUM_CHECKS (NUM_CHECKS)
  ) u_cmp (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .cmp_en         (cmp_en),
    .b_valid        (b_valid),
    .data_a         (rd_data_a),
    .data_b         (rd_data_b),
    .exp_a          (exp_a),
    .exp_b          (exp_b),
    .idx_a          (IW'(a_idx)),
    .idx_b          (IW'(b_idx)),
    .num_correct    (num_correct),
    .fail_valid     (fail_valid),
    .first_fail_idx (first_fail_idx)
  );

endmodule

// File: tb/tb_regfile_selfcheck.sv
// Bench for regfile_selfcheck: default build plus a 5-entry, zero-latency build with behavioural register files.
module tb_regfile_selfcheck;

  localparam int N0 = 12, RUN0 = 100, LAT0 = 1;
  localparam int N1 = 5,  RUN1 = 3,   LAT1 = 0;

  typedef struct {
    int nc;
    int ffi;
    bit pass;
    bit fv;
    int cyc;
  } res_t;

  int addr_tab [12] = '{3, 7, 1, 12, 9, 20, 4, 31, 15, 2, 26, 18};
  int val_tab  [12] = '{0, 5, 3, 8, 2, 1, 7, 40, 2, 8, 17, 25};

  logic clock = 1'b0;
  logic reset, start0, start1;

  logic [N0*5-1:0]  exp_addr0;
  logic [N0*32-1:0] exp_value0;
  logic [31:0] rd_data_a0, rd_data_b0;
  logic test0, we0, busy0, done0, pass0, fv0;
  logic [4:0] rd_addr_a0, rd_addr_b0;
  logic [3:0] nc0, ffi0;

  logic [N1*5-1:0]  exp_addr1;
  logic [N1*32-1:0] exp_value1;
  logic [31:0] rd_data_a1, rd_data_b1;
  logic test1, we1, busy1, done1, pass1, fv1;
  logic [4:0] rd_addr_a1, rd_addr_b1;
  logic [2:0] nc1, ffi1;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  res_t       res_q [$];
  logic [9:0] addr_q [$];
  logic [9:0] obs_q [$];
  int checks, passed, addr_viol, we_viol;
  logic busy_mid;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rd_data_a0 <= mem0[rd_addr_a0];
    rd_data_b0 <= mem0[rd_addr_b0];
  end
  assign rd_data_a1 = mem1[rd_addr_a1];
  assign rd_data_b1 = mem1[rd_addr_b1];

  regfile_selfcheck #(.DATA_W(32), .ADDR_W(5), .NUM_CHECKS(N0), .RUN_CYCLES(RUN0), .READ_LAT(LAT0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .exp_addr(exp_addr0), .exp_value(exp_value0),
    .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0), .test(test0), .t_ctrl_writeEnable(we0),
    .rd_addr_a(rd_addr_a0), .rd_addr_b(rd_addr_b0), .busy(busy0), .done(done0), .pass_all(pass0),
    .num_correct(nc0), .fail_valid(fv0), .first_fail_idx(ffi0));

  regfile_selfcheck #(.DATA_W(32), .ADDR_W(5), .NUM_CHECKS(N1), .RUN_CYCLES(RUN1), .READ_LAT(LAT1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .exp_addr(exp_addr1), .exp_value(exp_value1),
    .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1), .test(test1), .t_ctrl_writeEnable(we1),
    .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1), .busy(busy1), .done(done1), .pass_all(pass1),
    .num_correct(nc1), .fail_valid(fv1), .first_fail_idx(ffi1));

  task automatic setup0();
    for (int k = 0; k < 32; k++) mem0[k] = 32'hC0DE_0000 | 32'(k);
    for (int i = 0; i < N0; i++) begin
      mem0[addr_tab[i]]        = 32'(val_tab[i]);
      exp_addr0[i*5 +: 5]      = 5'(addr_tab[i]);
      exp_value0[i*32 +: 32]   = 32'(val_tab[i]);
    end
  endtask

  task automatic setup1();
    for (int k = 0; k < 32; k++) mem1[k] = 32'hBEEF_0000 | 32'(k);
    mem1[0] = 32'h1234;
    for (int i = 0; i < N1; i++) begin
      mem1[addr_tab[i]]        = 32'(val_tab[i]);
      exp_addr1[i*5 +: 5]      = 5'(addr_tab[i]);
      exp_value1[i*32 +: 32]   = 32'(val_tab[i]);
    end
  endtask

  // Scoreboard push: expected outcome and address sequence come from the bench's register-file model.
  task automatic launch0();
    res_t r;
    int ff;
    r.nc = 0; ff = -1;
    for (int i = 0; i < N0; i++)
      if (mem0[addr_tab[i]] == 32'(val_tab[i])) r.nc++;
      else if (ff < 0) ff = i;
    r.fv = (ff >= 0); r.ffi = (ff < 0) ? 0 : ff; r.pass = (r.nc == N0);
    r.cyc = RUN0 + ((N0 + 1) / 2) * (1 + LAT0) + 1;
    res_q.push_back(r);
    addr_q.delete(); obs_q.delete(); addr_viol = 0; we_viol = 0;
    for (int p = 0; p < (N0 + 1) / 2; p++)
      for (int k = 0; k < 1 + LAT0; k++)
        addr_q.push_back({5'(addr_tab[2*p]), (2*p+1 < N0) ? 5'(addr_tab[2*p+1]) : 5'd0});
    @(posedge clock); #1 start0 = 1'b1;
    @(posedge clock); #1 start0 = 1'b0;
  endtask

  task automatic launch1();
    res_t r;
    int ff;
    r.nc = 0; ff = -1;
    for (int i = 0; i < N1; i++)
      if (mem1[addr_tab[i]] == 32'(val_tab[i])) r.nc++;
      else if (ff < 0) ff = i;
    r.fv = (ff >= 0); r.ffi = (ff < 0) ? 0 : ff; r.pass = (r.nc == N1);
    r.cyc = RUN1 + ((N1 + 1) / 2) * (1 + LAT1) + 1;
    res_q.push_back(r);
    addr_q.delete(); obs_q.delete(); addr_viol = 0; we_viol = 0;
    for (int p = 0; p < (N1 + 1) / 2; p++)
      addr_q.push_back({5'(addr_tab[2*p]), (2*p+1 < N1) ? 5'(addr_tab[2*p+1]) : 5'd0});
    @(posedge clock); #1 start1 = 1'b1;
    @(posedge clock); #1 start1 = 1'b0;
  endtask

  // Waits for done, logging test-port addresses; pokes start at the given cycles (-1 = never).
  task automatic wait0(output int cyc, output bit to, input int poke_a, input int poke_b);
    cyc = 0; to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock); #1;
      cyc++;
      start0 = (cyc == poke_a) || (cyc == poke_b);
      if (cyc == 50) busy_mid = busy0;
      if (we0) we_viol++;
      if (test0) obs_q.push_back({rd_addr_a0, rd_addr_b0});
      else if (rd_addr_a0 != 5'd0 || rd_addr_b0 != 5'd0) addr_viol++;
      if (done0) begin to = 1'b0; break; end
    end
    start0 = 1'b0;
  endtask

  task automatic wait1(output int cyc, output bit to);
    cyc = 0; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      cyc++;
      if (test1) obs_q.push_back({rd_addr_a1, rd_addr_b1});
      else if (rd_addr_a1 != 5'd0 || rd_addr_b1 != 5'd0) addr_viol++;
      if (done1) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if ({test0, busy0, done0, pass0, fv0, we0} !== 6'b0) $display("FAIL reset.flags got %b want 000000", {test0, busy0, done0, pass0, fv0, we0}); else passed++;
    checks++; if ({nc0, ffi0, rd_addr_a0, rd_addr_b0} !== 18'd0) $display("FAIL reset.values got %h want 0", {nc0, ffi0, rd_addr_a0, rd_addr_b0}); else passed++;
    checks++; if ({test1, busy1, done1, nc1, ffi1} !== 9'd0) $display("FAIL reset.dut1 got %h want 0", {test1, busy1, done1, nc1, ffi1}); else passed++;
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    checks++; if ({busy0, test0, done0, busy1} !== 4'b0) $display("FAIL reset.idle_after got %b want 0000", {busy0, test0, done0, busy1}); else passed++;
  endtask

  task automatic test_all_match();
    res_t r; int cyc, bad; bit to;
    setup0(); launch0(); wait0(cyc, to, -1, -1);
    r = res_q.pop_front();
    checks++; if (to) $display("FAIL all_match.timeout done never rose, want it by cycle %0d", r.cyc); else passed++;
    checks++; if (cyc !== r.cyc) $display("FAIL all_match.latency got %0d want %0d", cyc, r.cyc); else passed++;
    checks++; if (nc0 !== 4'(r.nc)) $display("FAIL all_match.num_correct got %0d want %0d", nc0, r.nc); else passed++;
    checks++; if ({pass0, fv0} !== {r.pass, r.fv}) $display("FAIL all_match.pass_fail got %b want %b", {pass0, fv0}, {r.pass, r.fv}); else passed++;
    checks++; if (busy_mid !== 1'b1) $display("FAIL all_match.busy_in_run got %b want 1", busy_mid); else passed++;
    bad = (obs_q.size() != addr_q.size()) ? 1 : 0;
    for (int i = 0; i < obs_q.size() && i < addr_q.size(); i++) if (obs_q[i] !== addr_q[i]) bad++;
    checks++; if (bad != 0) $display("FAIL all_match.addr_seq got %0d bad (obs %0d entries, want %0d)", bad, obs_q.size(), addr_q.size()); else passed++;
    checks++; if (addr_viol + we_viol != 0) $display("FAIL all_match.idle_addr_we got %0d violations want 0", addr_viol + we_viol); else passed++;
    repeat (5) @(posedge clock);
    #1;
    checks++; if ({done0, pass0, busy0, test0} !== 4'b1100 || nc0 !== 4'(r.nc)) $display("FAIL all_match.sticky got done/pass/busy/test=%b nc=%0d want 1100 nc=%0d", {done0, pass0, busy0, test0}, nc0, r.nc); else passed++;
  endtask

  task automatic test_single_fail();
    res_t r; int cyc; bit to;
    setup0(); mem0[addr_tab[7]] = 32'd41; launch0(); wait0(cyc, to, -1, -1);
    r = res_q.pop_front();
    checks++; if (to) $display("FAIL single_fail.timeout done never rose"); else passed++;
    checks++; if (nc0 !== 4'(r.nc)) $display("FAIL single_fail.num_correct got %0d want %0d", nc0, r.nc); else passed++;
    checks++; if ({fv0, ffi0} !== {r.fv, 4'(r.ffi)}) $display("FAIL single_fail.first_fail got v=%b idx=%0d want v=%b idx=%0d", fv0, ffi0, r.fv, r.ffi); else passed++;
    checks++; if (pass0 !== r.pass) $display("FAIL single_fail.pass_all got %b want %b", pass0, r.pass); else passed++;
  endtask

  task automatic test_pair_fail();
    res_t r; int cyc; bit to;
    setup0(); mem0[addr_tab[4]] = 32'd99; mem0[addr_tab[5]] = 32'd98; launch0(); wait0(cyc, to, -1, -1);
    r = res_q.pop_front();
    checks++; if (to) $display("FAIL pair_fail.timeout done never rose"); else passed++;
    checks++; if (nc0 !== 4'(r.nc)) $display("FAIL pair_fail.num_correct got %0d want %0d", nc0, r.nc); else passed++;
    checks++; if ({fv0, ffi0} !== {r.fv, 4'(r.ffi)}) $display("FAIL pair_fail.first_fail got v=%b idx=%0d want v=%b idx=%0d", fv0, ffi0, r.fv, r.ffi); else passed++;
  endtask

  task automatic test_busy_start();
    res_t r; int cyc; bit to;
    setup0(); mem0[addr_tab[2]] = 32'd77; launch0(); wait0(cyc, to, 40, 104);
    r = res_q.pop_front();
    checks++; if (to) $display("FAIL busy_start.timeout done never rose"); else passed++;
    checks++; if (cyc !== r.cyc) $display("FAIL busy_start.latency got %0d want %0d", cyc, r.cyc); else passed++;
    checks++; if (nc0 !== 4'(r.nc) || ffi0 !== 4'(r.ffi)) $display("FAIL busy_start.counters got nc=%0d idx=%0d want nc=%0d idx=%0d", nc0, ffi0, r.nc, r.ffi); else passed++;
  endtask

  task automatic test_reset_mid();
    res_t r; int cyc, seen; bit to;
    setup0(); launch0();
    seen = 0;
    for (int i = 0; i < 300 && seen < 6; i++) begin
      @(posedge clock); #1;
      if (test0) seen++;
    end
    checks++; if (seen != 6) $display("FAIL reset_mid.reach_wait got %0d test cycles want 6", seen); else passed++;
    reset = 1'b1;
    #1;
    checks++; if ({test0, busy0, rd_addr_a0, rd_addr_b0, nc0} !== 16'd0) $display("FAIL reset_mid.async got %h want 0", {test0, busy0, rd_addr_a0, rd_addr_b0, nc0}); else passed++;
    @(posedge clock); #1 reset = 1'b0;
    void'(res_q.pop_front());
    launch0(); wait0(cyc, to, -1, -1);
    r = res_q.pop_front();
    checks++; if (to || cyc !== r.cyc) $display("FAIL reset_mid.rerun_latency got %0d (timeout %b) want %0d", cyc, to, r.cyc); else passed++;
    checks++; if (nc0 !== 4'(r.nc) || pass0 !== r.pass) $display("FAIL reset_mid.rerun_result got nc=%0d pass=%b want nc=%0d pass=%b", nc0, pass0, r.nc, r.pass); else passed++;
  endtask

  task automatic test_odd();
    res_t r; int cyc, bad; bit to;
    setup1(); launch1(); wait1(cyc, to);
    r = res_q.pop_front();
    checks++; if (to || cyc !== r.cyc) $display("FAIL odd.latency got %0d (timeout %b) want %0d", cyc, to, r.cyc); else passed++;
    checks++; if (nc1 !== 3'(r.nc) || {pass1, fv1} !== {r.pass, r.fv}) $display("FAIL odd.result got nc=%0d pass/fv=%b want nc=%0d pass/fv=%b", nc1, {pass1, fv1}, r.nc, {r.pass, r.fv}); else passed++;
    bad = (obs_q.size() != addr_q.size()) ? 1 : 0;
    for (int i = 0; i < obs_q.size() && i < addr_q.size(); i++) if (obs_q[i] !== addr_q[i]) bad++;
    checks++; if (bad != 0) $display("FAIL odd.addr_seq got %0d bad (obs %0d entries, want %0d)", bad, obs_q.size(), addr_q.size()); else passed++;
    checks++; if (we1 !== 1'b0 || addr_viol != 0) $display("FAIL odd.idle_addr_we got we=%b viol=%0d want 0", we1, addr_viol); else passed++;
  endtask

  task automatic test_odd_last_fail();
    res_t r; int cyc; bit to;
    setup1(); mem1[addr_tab[4]] = 32'd6; launch1(); wait1(cyc, to);
    r = res_q.pop_front();
    checks++; if (to) $display("FAIL odd_last.timeout done never rose"); else passed++;
    checks++; if (nc1 !== 3'(r.nc) || {fv1, ffi1} !== {r.fv, 3'(r.ffi)}) $display("FAIL odd_last.result got nc=%0d v=%b idx=%0d want nc=%0d v=%b idx=%0d", nc1, fv1, ffi1, r.nc, r.fv, r.ffi); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; addr_viol = 0; we_viol = 0; busy_mid = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    exp_addr0 = '0; exp_value0 = '0; exp_addr1 = '0; exp_value1 = '0;
    for (int k = 0; k < 32; k++) begin mem0[k] = '0; mem1[k] = '0; end
    test_reset();
    test_all_match();
    test_single_fail();
    test_pair_fail();
    test_busy_start();
    test_reset_mid();
    test_odd();
    test_odd_last_fail();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
